// File: rtl/pulse_meas_pkg.sv
// ============================================================================
// Module   : pulse_meas_pkg
// Purpose  : Shared defaults and types for the pulse-width measurement chain.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pulse_meas_pkg;

    localparam int unsigned CNT_W_DEFAULT          = 32;
    localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 100_000_000;

    typedef enum logic [0:0] {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

endpackage : pulse_meas_pkg

`default_nettype wire

// File: rtl/pulse_width_averager_if.sv
// ============================================================================
// Module   : pulse_width_averager_if
// Purpose  : Sample stream in, averaged result out (valid/ready) plus status.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pulse_width_averager_if #(
    parameter int unsigned CNT_W = 32
);
    logic             clear;
    logic [CNT_W-1:0] width_in;
    logic             width_valid;
    logic [CNT_W-1:0] avg_width;
    logic [CNT_W-1:0] min_width;
    logic [CNT_W-1:0] max_width;
    logic             no_signal;
    logic             result_valid;
    logic             result_ready;
    logic             overrun;

    // master: the environment feeding samples and consuming results
    modport master (
        output clear, width_in, width_valid, result_ready,
        input  avg_width, min_width, max_width, no_signal, result_valid, overrun
    );

    modport slave (
        input  clear, width_in, width_valid, result_ready,
        output avg_width, min_width, max_width, no_signal, result_valid, overrun
    );
endinterface : pulse_width_averager_if

`default_nettype wire

// File: rtl/width_timeout_timer.sv
// ============================================================================
// Module   : width_timeout_timer
// Purpose  : Idle counter; single-cycle expire at TIMEOUT_CYCLES-1, reloads 0.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module width_timeout_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 100_000_000
) (
    input  wire logic sys_clk,
    input  wire logic sys_rst_n,
    input  wire logic restart_i,
    output logic      expire_o
);

    localparam int unsigned c_TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_TW-1:0] c_LAST = c_TW'(TIMEOUT_CYCLES - 1);

    logic [c_TW-1:0] cnt_q;
    logic [c_TW-1:0] cnt_d;

    assign expire_o = (cnt_q == c_LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (restart_i || expire_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : width_timeout_timer

`default_nettype wire

// File: rtl/pulse_width_averager.sv
// ============================================================================
// Module   : pulse_width_averager
// Purpose  : Averages 2^LOG2_N width samples into a one-deep result slot with
//            idle watchdog. Define PULSE_WIDTH_MINMAX_EN for min/max trackers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pulse_width_averager
    import pulse_meas_pkg::*;
#(
    parameter int unsigned LOG2_N         = 4,
    parameter int unsigned CNT_W          = CNT_W_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  wire logic             sys_clk,
    input  wire logic             sys_rst_n,
    pulse_width_averager_if.slave bus
);

    localparam int unsigned     c_SUM_W    = CNT_W + LOG2_N;
    localparam logic [LOG2_N:0] c_LAST_IDX = (LOG2_N + 1)'((2 ** LOG2_N) - 1);

    logic [c_SUM_W-1:0] sum_q;
    logic [LOG2_N:0]    scnt_q;
    logic [c_SUM_W-1:0] sum_next;
    logic               take;
    logic               complete;
    logic               expire;
    logic               timeout;
    logic               accept;
    logic               load;

    slot_state_e state_q, state_d;
    logic        overrun_q, overrun_d;
    logic [CNT_W-1:0] avg_q;
    logic             nosig_q;

    // A sample coincident with clear is dropped; a sample beats a timeout.
    assign take     = bus.width_valid & ~bus.clear;
    assign sum_next = sum_q + c_SUM_W'(bus.width_in);
    assign complete = take & (scnt_q == c_LAST_IDX);
    assign timeout  = expire & ~bus.clear & ~bus.width_valid;
    assign accept   = (state_q == SLOT_FULL) & bus.result_ready;

    width_timeout_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .restart_i (bus.clear | bus.width_valid),
        .expire_o  (expire)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sum_q  <= '0;
            scnt_q <= '0;
        end else if (bus.clear || complete || timeout) begin
            sum_q  <= '0;
            scnt_q <= '0;
        end else if (take) begin
            sum_q  <= sum_next;
            scnt_q <= scnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        overrun_d = overrun_q;
        load      = 1'b0;
        if (bus.clear) begin
            state_d   = SLOT_EMPTY;
            overrun_d = 1'b0;
        end else begin
            case (state_q)
                SLOT_EMPTY: begin
                    if (complete || timeout) begin
                        load    = 1'b1;
                        state_d = SLOT_FULL;
                    end
                end
                SLOT_FULL: begin
                    if (complete || timeout) begin
                        if (accept) begin
                            load = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end else if (accept) begin
                        state_d = SLOT_EMPTY;
                    end
                end
                default: state_d = SLOT_EMPTY;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= SLOT_EMPTY;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            overrun_q <= overrun_d;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            avg_q   <= '0;
            nosig_q <= 1'b0;
        end else if (load) begin
            avg_q   <= complete ? CNT_W'(sum_next >> LOG2_N) : '0;
            nosig_q <= timeout;
        end
    end

`ifdef PULSE_WIDTH_MINMAX_EN
    logic [CNT_W-1:0] trk_min_q, trk_max_q;
    logic [CNT_W-1:0] min_out_q, max_out_q;
    logic [CNT_W-1:0] min_new, max_new;

    assign min_new = (bus.width_in < trk_min_q) ? bus.width_in : trk_min_q;
    assign max_new = (bus.width_in > trk_max_q) ? bus.width_in : trk_max_q;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            trk_min_q <= '1;
            trk_max_q <= '0;
        end else if (bus.clear || complete || timeout) begin
            trk_min_q <= '1;
            trk_max_q <= '0;
        end else if (take) begin
            trk_min_q <= min_new;
            trk_max_q <= max_new;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            min_out_q <= '0;
            max_out_q <= '0;
        end else if (load) begin
            min_out_q <= complete ? min_new : '0;
            max_out_q <= complete ? max_new : '0;
        end
    end

    assign bus.min_width = min_out_q;
    assign bus.max_width = max_out_q;
`else
    assign bus.min_width = '0;
    assign bus.max_width = '0;
`endif

    assign bus.avg_width    = avg_q;
    assign bus.no_signal    = nosig_q;
    assign bus.result_valid = (state_q == SLOT_FULL);
    assign bus.overrun      = overrun_q;

endmodule : pulse_width_averager

`default_nettype wire

// File: tb/tb_pulse_width_averager.sv
// ============================================================================
// Module   : tb_pulse_width_averager
// Purpose  : Scoreboard bench: window-level reference model vs averager DUT.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pulse_width_averager;

    localparam int unsigned LOG2_N = 2;
    localparam int unsigned N      = 4;
    localparam int unsigned TMO    = 50;

    typedef struct {
        logic [31:0] avg;
        logic [31:0] mn;
        logic [31:0] mx;
        logic        ns;
    } res_t;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        clr = 1'b0;
    logic        vld = 1'b0;
    logic [31:0] win_v = '0;
    logic        rdy = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    res_t        exp_q[$];
    logic [31:0] win[$];
    logic        m_full = 1'b0;
    logic        m_ovr  = 1'b0;
    longint      cyc    = 0;
    longint      last   = 0;

    pulse_width_averager_if #(.CNT_W(32)) bus ();

    assign bus.clear        = clr;
    assign bus.width_valid  = vld;
    assign bus.width_in     = win_v;
    assign bus.result_ready = rdy;

    pulse_width_averager #(
        .LOG2_N         (LOG2_N),
        .CNT_W          (32),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    always #5 sys_clk = ~sys_clk;

    function automatic void chk(string name, logic [63:0] got, logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endfunction

    // Reference model: one step per clock edge, in terms of windows and a slot.
    initial begin
        res_t        r;
        logic        acc;
        logic        have;
        logic [63:0] s;
        forever begin
            @(posedge sys_clk);
            cyc++;
            if (!sys_rst_n) begin
                win.delete();
                exp_q.delete();
                m_full = 1'b0;
                m_ovr  = 1'b0;
                last   = cyc;
            end else begin
                acc  = m_full && rdy;
                have = 1'b0;
                if (clr) begin
                    if (m_full && !acc) void'(exp_q.pop_back());
                    win.delete();
                    m_full = 1'b0;
                    m_ovr  = 1'b0;
                    last   = cyc;
                end else begin
                    if (vld) begin
                        win.push_back(win_v);
                        last = cyc;
                        if (win.size() == N) begin
                            s    = 0;
                            r.mn = 32'hFFFF_FFFF;
                            r.mx = 32'h0;
                            foreach (win[i]) begin
                                s += 64'(win[i]);
                                if (win[i] < r.mn) r.mn = win[i];
                                if (win[i] > r.mx) r.mx = win[i];
                            end
                            r.avg = 32'(s / N);
                            r.ns  = 1'b0;
`ifndef PULSE_WIDTH_MINMAX_EN
                            r.mn = 32'h0;
                            r.mx = 32'h0;
`endif
                            win.delete();
                            have = 1'b1;
                        end
                    end else if (cyc - last == TMO) begin
                        win.delete();
                        r.avg = 32'h0;
                        r.mn  = 32'h0;
                        r.mx  = 32'h0;
                        r.ns  = 1'b1;
                        have  = 1'b1;
                        last  = cyc;
                    end
                    if (have) begin
                        if (!m_full || acc) begin
                            exp_q.push_back(r);
                            m_full = 1'b1;
                        end else begin
                            m_ovr = 1'b1;
                        end
                    end else if (acc) begin
                        m_full = 1'b0;
                    end
                end
            end
        end
    end

    // Monitor: mid-cycle sampling; an accept is valid & ready ahead of the edge.
    initial begin
        res_t e;
        forever begin
            @(negedge sys_clk);
            if (!sys_rst_n) begin
                chk("reset_outputs",
                    {bus.avg_width, bus.min_width | bus.max_width},
                    64'h0);
                chk("reset_flags",
                    {61'h0, bus.no_signal, bus.result_valid, bus.overrun}, 64'h0);
            end else begin
                chk("result_valid", 64'(bus.result_valid), 64'(m_full));
                chk("overrun", 64'(bus.overrun), 64'(m_ovr));
                if (bus.result_valid && rdy) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_result", 64'(1), 64'(0));
                    end else begin
                        e = exp_q.pop_front();
                        chk("avg_width", 64'(bus.avg_width), 64'(e.avg));
                        chk("min_width", 64'(bus.min_width), 64'(e.mn));
                        chk("max_width", 64'(bus.max_width), 64'(e.mx));
                        chk("no_signal", 64'(bus.no_signal), 64'(e.ns));
                    end
                end
            end
        end
    end

    task automatic step(input logic v, input logic [31:0] w, input logic c, input logic r);
        vld   = v;
        win_v = w;
        clr   = c;
        rdy   = r;
        @(posedge sys_clk);
        #1;
    endtask

    task automatic idle(input int n, input logic r);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, r);
    endtask

    initial begin
        int          mode;
        logic [31:0] w;
        repeat (3) @(posedge sys_clk);
        #1 sys_rst_n = 1'b1;

        // basic window
        step(1'b1, 32'd10, 1'b0, 1'b1);
        step(1'b1, 32'd20, 1'b0, 1'b1);
        step(1'b1, 32'd30, 1'b0, 1'b1);
        step(1'b1, 32'd41, 1'b0, 1'b1);
        idle(3, 1'b1);

        // overrun: two windows of 100 then two of 200 with no consumer
        for (int i = 0; i < 8; i++) step(1'b1, 32'd100, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, 32'd200, 1'b0, 1'b0);
        idle(2, 1'b0);
        idle(1, 1'b1);
        idle(2, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);

        // accept coinciding with the next completion
        for (int i = 0; i < 4; i++) step(1'b1, 32'd3, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 32'd7, 1'b0, 1'b0);
        step(1'b1, 32'd7, 1'b0, 1'b1);
        idle(2, 1'b1);

        // timeout discards partial window
        step(1'b1, 32'd5, 1'b0, 1'b1);
        step(1'b1, 32'd5, 1'b0, 1'b1);
        idle(55, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 32'd9, 1'b0, 1'b1);
        idle(2, 1'b1);

        // full-scale
        for (int i = 0; i < 4; i++) step(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1);
        idle(2, 1'b1);

        // clear with a coincident sample
        step(1'b1, 32'd1000, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 32'd3, 1'b0, 1'b1);
        idle(2, 1'b1);

        // async reset mid-window with a pending result
        for (int i = 0; i < 6; i++) step(1'b1, 32'd8, 1'b0, 1'b0);
        sys_rst_n = 1'b0;
        idle(3, 1'b0);
        sys_rst_n = 1'b1;

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            mode = int'($urandom_range(0, 99));
            case ($urandom_range(0, 3))
                0:       w = $urandom_range(0, 15);
                1:       w = 32'hFFFF_FFFF - $urandom_range(0, 3);
                default: w = $urandom;
            endcase
            if (mode < 2) begin
                idle(int'($urandom_range(30, 70)), 1'($urandom_range(0, 1)));
            end else begin
                step(1'($urandom_range(0, 2) != 0), w, 1'(mode == 50),
                     1'($urandom_range(0, 2) == 0));
            end
        end

        idle(4, 1'b1);
        idle(2, 1'b0);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'(m_full ? 1 : 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_pulse_width_averager

`default_nettype wire
